// File: rtl/fpu_ss_pkg.sv
// Shared FPU subsystem types: write-back source encoding and the buffered load entry.
package fpu_ss_pkg;

    localparam int unsigned FLEN = 32;

    typedef enum logic [1:0] {
        WbNone = 2'd0,
        WbFpu  = 2'd1,
        WbLsu  = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [4:0]      rd;
        logic [FLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/fpu_ss_wb_fifo.sv
// Small circular buffer of wb_entry_t; fall-through to the write port is handled by the parent.
module fpu_ss_wb_fifo
    import fpu_ss_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_push,
    input  logic          i_pop,
    input  wb_entry_t     i_data,
    output wb_entry_t     o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    wb_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/fpu_ss_wb_arbiter.sv
// FP register-file write-port arbiter: buffered LSU loads vs. FPnew results with bounded FPU starvation.
// Optional FPU stall counter enabled by defining FPU_SS_WB_STALL_CNT_EN.
module fpu_ss_wb_arbiter
    import fpu_ss_pkg::*;
#(
    parameter  int unsigned FLEN           = 32,
    parameter  int unsigned LSU_FIFO_DEPTH = 2,
    parameter  int unsigned MAX_WAIT       = 4,
    localparam int unsigned CW             = $clog2(LSU_FIFO_DEPTH) + 1,
    localparam int unsigned SW             = $clog2(MAX_WAIT + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            fpu_out_valid_i,
    output logic            fpu_out_ready_o,
    input  logic            fpu_rd_is_fp_i,
    input  logic [4:0]      fpu_rd_i,
    input  logic [FLEN-1:0] fpu_data_i,
    input  logic            lsu_valid_i,
    input  logic            lsu_we_i,
    input  logic [4:0]      lsu_rd_i,
    input  logic [FLEN-1:0] lsu_data_i,
    output logic [CW-1:0]   lsu_credit_o,
    output logic            fpr_we_o,
    output logic [4:0]      fpr_waddr_o,
    output logic [FLEN-1:0] fpr_wdata_o,
    output logic [1:0]      wb_src_o,
    output logic            overflow_o,
    output logic [31:0]     stall_cnt_o
);

    wb_src_e       w_grant;
    wb_entry_t     w_lsu_in;
    wb_entry_t     w_fifo_head;
    wb_entry_t     w_head;
    logic          w_lsu_push;
    logic          w_lsu_pend;
    logic          w_fpu_req;
    logic          w_fpu_wait;
    logic          w_fifo_push;
    logic          w_fifo_pop;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [SW-1:0] r_starve;
    logic          r_overflow;

    assign w_lsu_in   = '{rd: lsu_rd_i, data: lsu_data_i};
    assign w_lsu_push = lsu_valid_i & lsu_we_i;
    assign w_lsu_pend = ~w_fifo_empty | w_lsu_push;
    assign w_head     = w_fifo_empty ? w_lsu_in : w_fifo_head;
    assign w_fpu_req  = fpu_out_valid_i & fpu_rd_is_fp_i;

    always_comb begin
        w_grant = WbNone;
        if (w_fpu_req && (r_starve == SW'(MAX_WAIT))) w_grant = WbFpu;
        else if (w_lsu_pend)                          w_grant = WbLsu;
        else if (w_fpu_req)                           w_grant = WbFpu;
    end

    assign w_fpu_wait = w_fpu_req & (w_grant != WbFpu);

    // An empty FIFO with a granted load writes straight through and never stores it.
    assign w_fifo_pop  = (w_grant == WbLsu) & ~w_fifo_empty;
    assign w_fifo_push = w_lsu_push & ~((w_grant == WbLsu) & w_fifo_empty);

    fpu_ss_wb_fifo #(
        .DEPTH (LSU_FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_data  (w_lsu_in),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_comb begin
        fpr_waddr_o = '0;
        fpr_wdata_o = '0;
        case (w_grant)
            WbFpu: begin
                fpr_waddr_o = fpu_rd_i;
                fpr_wdata_o = fpu_data_i;
            end
            WbLsu: begin
                fpr_waddr_o = w_head.rd;
                fpr_wdata_o = w_head.data;
            end
            default: ;
        endcase
    end

    assign fpr_we_o        = (w_grant != WbNone);
    assign wb_src_o        = w_grant;
    assign fpu_out_ready_o = ~fpu_rd_is_fp_i | (w_grant == WbFpu);
    assign lsu_credit_o    = CW'(LSU_FIFO_DEPTH) - w_fifo_count;
    assign overflow_o      = r_overflow;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_starve   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_fpu_wait) begin
                if (r_starve != SW'(MAX_WAIT)) r_starve <= r_starve + SW'(1);
            end else begin
                r_starve <= '0;
            end
            if (w_fifo_push && w_fifo_full && !w_fifo_pop) r_overflow <= 1'b1;
        end
    end

`ifdef FPU_SS_WB_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)         r_stall_cnt <= '0;
        else if (w_fpu_wait) r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// Directed and random checks of the write-back arbiter against a queue-based reference model.
module tb_fpu_ss_wb_arbiter;
  import fpu_ss_pkg::*;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned MAXW  = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned EW    = 5 + W;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          fpu_out_valid_i = 1'b0;
  logic          fpu_out_ready_o;
  logic          fpu_rd_is_fp_i = 1'b0;
  logic [4:0]    fpu_rd_i = '0;
  logic [W-1:0]  fpu_data_i = '0;
  logic          lsu_valid_i = 1'b0;
  logic          lsu_we_i = 1'b0;
  logic [4:0]    lsu_rd_i = '0;
  logic [W-1:0]  lsu_data_i = '0;
  logic [CW-1:0] lsu_credit_o;
  logic          fpr_we_o;
  logic [4:0]    fpr_waddr_o;
  logic [W-1:0]  fpr_wdata_o;
  logic [1:0]    wb_src_o;
  logic          overflow_o;
  logic [31:0]   stall_cnt_o;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [EW-1:0] exp_q[$];
  int            m_starve = 0;
  bit            m_ovf = 1'b0;
  logic [31:0]   m_stall = '0;

  fpu_ss_wb_arbiter #(
    .FLEN           (W),
    .LSU_FIFO_DEPTH (DEPTH),
    .MAX_WAIT       (MAXW)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .fpu_out_valid_i (fpu_out_valid_i),
    .fpu_out_ready_o (fpu_out_ready_o),
    .fpu_rd_is_fp_i  (fpu_rd_is_fp_i),
    .fpu_rd_i        (fpu_rd_i),
    .fpu_data_i      (fpu_data_i),
    .lsu_valid_i     (lsu_valid_i),
    .lsu_we_i        (lsu_we_i),
    .lsu_rd_i        (lsu_rd_i),
    .lsu_data_i      (lsu_data_i),
    .lsu_credit_o    (lsu_credit_o),
    .fpr_we_o        (fpr_we_o),
    .fpr_waddr_o     (fpr_waddr_o),
    .fpr_wdata_o     (fpr_wdata_o),
    .wb_src_o        (wb_src_o),
    .overflow_o      (overflow_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit fv, input bit fp, input logic [4:0] frd, input logic [W-1:0] fd,
                        input bit lv, input bit lwe, input logic [4:0] lrd, input logic [W-1:0] ld);
    fpu_out_valid_i = fv;
    fpu_rd_is_fp_i  = fp;
    fpu_rd_i        = frd;
    fpu_data_i      = fd;
    lsu_valid_i     = lv;
    lsu_we_i        = lwe;
    lsu_rd_i        = lrd;
    lsu_data_i      = ld;
  endtask

  function automatic logic [31:0] exp_stall();
`ifdef FPU_SS_WB_STALL_CNT_EN
    return m_stall;
`else
    return 32'd0;
`endif
  endfunction

  // Called at posedge+1 with inputs applied; checks this cycle, advances the model, moves to next posedge+1.
  task automatic step();
    bit            push;
    bit            req;
    int            g;
    logic [EW-1:0] in_e;
    logic [EW-1:0] hd;
    #2;
    push = lsu_valid_i && lsu_we_i;
    req  = fpu_out_valid_i && fpu_rd_is_fp_i;
    in_e = {lsu_rd_i, lsu_data_i};
    if (req && m_starve == MAXW)             g = 1;
    else if (exp_q.size() > 0 || push)       g = 2;
    else if (req)                            g = 1;
    else                                     g = 0;
    hd = (exp_q.size() > 0) ? exp_q[0] : in_e;

    chk("fpr_we", 64'(fpr_we_o), 64'(g != 0));
    chk("wb_src", 64'(wb_src_o), 64'(g));
    chk("fpu_ready", 64'(fpu_out_ready_o), 64'(!fpu_rd_is_fp_i || g == 1));
    chk("credit", 64'(lsu_credit_o), 64'(DEPTH - exp_q.size()));
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
    chk("stall_cnt", 64'(stall_cnt_o), 64'(exp_stall()));
    if (g == 1) begin
      chk("waddr_fpu", 64'(fpr_waddr_o), 64'(fpu_rd_i));
      chk("wdata_fpu", 64'(fpr_wdata_o), 64'(fpu_data_i));
    end else if (g == 2) begin
      chk("waddr_lsu", 64'(fpr_waddr_o), 64'(hd[EW-1 -: 5]));
      chk("wdata_lsu", 64'(fpr_wdata_o), 64'(hd[W-1:0]));
    end

    if (g == 2 && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      if (push) exp_q.push_back(in_e);
    end else if (g != 2 && push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(in_e);
      else                      m_ovf = 1'b1;
    end
    if (req && g != 1) begin
      m_starve = (m_starve < MAXW) ? m_starve + 1 : MAXW;
      m_stall  = m_stall + 32'd1;
    end else begin
      m_starve = 0;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.delete();
    m_starve = 0;
    m_ovf    = 1'b0;
    m_stall  = '0;
    #2;
    chk("rst_credit", 64'(lsu_credit_o), 64'(DEPTH));
    chk("rst_we", 64'(fpr_we_o), 64'd0);
    chk("rst_src", 64'(wb_src_o), 64'(WbNone));
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_stall", 64'(stall_cnt_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    @(posedge clk_i);
    #1;
    do_reset();

    // FPU only
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 5'd3, 32'h3F80_0000, 0, 0, 0, 0);
      step();
    end

    // LSU bypass with empty FIFO
    set_in(0, 1, 0, 0, 1, 1, 5'd7, 32'h4000_0000);
    step();
    // Store (no write) is ignored
    set_in(0, 1, 0, 0, 1, 0, 5'd9, 32'h1234_5678);
    step();

    // Same-cycle conflict: LSU wins, FPU next
    set_in(1, 1, 5'd1, 32'hAAAA_0001, 1, 1, 5'd2, 32'hBBBB_0002);
    step();
    set_in(1, 1, 5'd1, 32'hAAAA_0001, 0, 0, 0, 0);
    step();

    // Starvation: four refusals, forced grant on the fifth
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 5'd4, 32'hC0DE_0000, 1, 1, 5'(10 + i), 32'h5000_0000 + i);
      step();
    end
    chk("starve_credit", 64'(lsu_credit_o), 64'(DEPTH - 1));

    // Keep starving until the FIFO overflows
    for (int i = 0; i < 12; i++) begin
      set_in(1, 1, 5'd5, 32'hC0DE_1000 + i, 1, 1, 5'(16 + i), 32'h6000_0000 + i);
      step();
    end
    chk("overflow_sticky", 64'(overflow_o), 64'd1);

    // Integer FPU result passes while the LSU writes
    set_in(1, 0, 5'd8, 32'h0000_0008, 1, 1, 5'd30, 32'h7000_0000);
    step();

    // Drain
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
    chk("drain_credit", 64'(lsu_credit_o), 64'(DEPTH));

    do_reset();

    // Random traffic with a mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        set_in(1, 1, 5'd1, 32'h1, 1, 1, 5'd2, 32'h2);
        step();
        do_reset();
      end
      set_in($urandom_range(0, 1), $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 5'($urandom_range(0, 31)), $urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
